// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and constants for the MAC lane sequencer.
// State encoding, default widths and (8,5) result bounds.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mac_state_e;

   localparam int ACC_W_DEF     = 16;
   localparam int LEN_W_DEF     = 8;
   localparam int IFDATA_SIZE   = 8;
   localparam int WDATA_SIZE    = 8;
   localparam int MULT_OUT_SIZE = 8;

   localparam logic signed [MULT_OUT_SIZE-1:0] RES_MAX = 8'sd127;
   localparam logic signed [MULT_OUT_SIZE-1:0] RES_MIN = -8'sd128;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Job, operand and result handshake bundle for the MAC sequencer.
// master = job/operand source and result sink, slave = sequencer.
interface mac_seq_ctrl_if
   import mac_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
);
   logic                     start;
   logic [LEN_W-1:0]         len;
   logic                     busy;
   logic                     in_valid;
   logic                     in_ready;
   logic [IFDATA_SIZE-1:0]   in_act;
   logic [WDATA_SIZE-1:0]    in_wgt;
   logic                     res_valid;
   logic                     res_ready;
   logic [MULT_OUT_SIZE-1:0] res_data;
   logic                     res_ovf;

   modport master (
      output start, len, in_valid, in_act, in_wgt, res_ready,
      input  busy, in_ready, res_valid, res_data, res_ovf
   );

   modport slave (
      input  start, len, in_valid, in_act, in_wgt, res_ready,
      output busy, in_ready, res_valid, res_data, res_ovf
   );
endinterface

// File: rtl/mac_seq_ctrl_mult_stage.sv
// Combinational (8,7)u x (8,6)s multiply, truncated to (8,5).
// Product bits [15:8] of the (16,13) result are kept.
module mac_mult_stage
   import mac_pkg::*;
(
   input  logic [IFDATA_SIZE-1:0]   act_i,
   input  logic [WDATA_SIZE-1:0]    wgt_i,
   output logic [MULT_OUT_SIZE-1:0] prod_o
);
   logic signed [8:0]  act_s;
   logic signed [8:0]  wgt_s;
   logic signed [17:0] full;

   assign act_s = $signed({1'b0, act_i});
   assign wgt_s = $signed({wgt_i[WDATA_SIZE-1], wgt_i});

   // Zero-extended activation times sign-extended weight
   always_comb begin
      full   = act_s * wgt_s;
      prod_o = full[15:8];
   end
endmodule

// File: rtl/mac_seq_ctrl.sv
// MAC lane sequencer: streams len pairs, accumulates, returns (8,5).
// Define MAC_SAT_EN for saturating accumulate and clamped result.
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   mac_seq_ctrl_if.slave bus
);
   mac_state_e                state_q, state_d;
   logic [LEN_W-1:0]          cnt_q, cnt_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [MULT_OUT_SIZE-1:0]  res_q, res_d;
   logic                      ovf_q, ovf_d;

   logic [MULT_OUT_SIZE-1:0]  prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   acc_sum;
   logic                      sum_clamp;
   logic [MULT_OUT_SIZE-1:0]  fin_res;
   logic                      fin_clamp;
   logic                      beat;

   mac_mult_stage u_mult (
      .act_i  (bus.in_act),
      .wgt_i  (bus.in_wgt),
      .prod_o (prod)
   );

   assign prod_ext = {{(ACC_W-MULT_OUT_SIZE){prod[MULT_OUT_SIZE-1]}}, prod};
   assign beat     = (state_q == RUN) && bus.in_valid;

`ifdef MAC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_HI = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_LO = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] FIN_HI = ACC_W'(RES_MAX);
   localparam logic signed [ACC_W-1:0] FIN_LO = ACC_W'(RES_MIN);

   logic signed [ACC_W:0] sum_w;

   // Saturating accumulate, then clamp the running value to (8,5)
   always_comb begin
      sum_w     = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
      sum_clamp = sum_w[ACC_W] != sum_w[ACC_W-1];
      if (sum_clamp)
         acc_sum = sum_w[ACC_W] ? ACC_LO : ACC_HI;
      else
         acc_sum = sum_w[ACC_W-1:0];
      fin_clamp = 1'b1;
      if (acc_sum > FIN_HI)
         fin_res = RES_MAX;
      else if (acc_sum < FIN_LO)
         fin_res = RES_MIN;
      else begin
         fin_res   = acc_sum[MULT_OUT_SIZE-1:0];
         fin_clamp = 1'b0;
      end
   end
`else
   // Wrapping accumulate, result is the low byte
   always_comb begin
      acc_sum   = acc_q + prod_ext;
      sum_clamp = 1'b0;
      fin_res   = acc_sum[MULT_OUT_SIZE-1:0];
      fin_clamp = 1'b0;
   end
`endif

   // Next-state, counter, accumulator and result register logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d = '0;
               ovf_d = 1'b0;
               if (bus.len != '0) begin
                  cnt_d   = bus.len;
                  state_d = RUN;
               end else begin
                  res_d   = '0;
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            if (beat) begin
               acc_d = acc_sum;
               cnt_d = cnt_q - 1'b1;
`ifdef MAC_SAT_EN
               ovf_d = ovf_q | sum_clamp;
`endif
               if (cnt_q == LEN_W'(1)) begin
                  res_d   = fin_res;
`ifdef MAC_SAT_EN
                  ovf_d   = ovf_q | sum_clamp | fin_clamp;
`endif
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (bus.res_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy      = state_q != IDLE;
   assign bus.in_ready  = state_q == RUN;
   assign bus.res_valid = state_q == DONE;
   assign bus.res_data  = res_q;
`ifdef MAC_SAT_EN
   assign bus.res_ovf   = ovf_q;
`else
   assign bus.res_ovf   = 1'b0;
`endif

   logic unused_ok;
   assign unused_ok = &{1'b0, sum_clamp, fin_clamp};
endmodule
